// File: rtl/app_c2h_gen_pkg.sv
// Shared definitions for the C2H pattern generator: FSM encoding, default widths,
// and the last-beat byte-enable mask helper.
package para_def;

    localparam int DATA_W_DEF = 64;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2
    } state_e;

    // Sized for the widest legal beat (512 bits); callers truncate to KEEP_W.
    function automatic logic [63:0] keep_mask(input int unsigned rem);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < rem) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/app_c2h_gen_if.sv
// AXI4-Stream channel between the pattern generator and the DMA C2H slave.
interface app_c2h_gen_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/app_c2h_gen_pat.sv
// Combinational beat builder: lane k carries (byte_off + k + pkt_idx) mod 256.
module app_c2h_pat #(
    parameter int DATA_W = 64
) (
    input  logic [7:0]        off_i,
    input  logic [7:0]        idx_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int KEEP_W = DATA_W / 8;

    logic [7:0] base;
    assign base = off_i + idx_i;

    for (genvar k = 0; k < KEEP_W; k++) begin : g_lane
        assign data_o[8*k +: 8] = base + 8'(k);
    end

endmodule

// File: rtl/app_c2h_gen.sv
// C2H stream pattern generator: on a run rising edge, emits pkt_num packets of
// pkt_len bytes with a deterministic byte pattern; all outputs registered.
module app_c2h_gen
    import para_def::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             usr_clk,
    input  logic             usr_rst_n,
    input  logic             usr_c2h0r_run_i,
    input  logic [LEN_W-1:0] pkt_len_i,
    input  logic [LEN_W-1:0] pkt_num_i,
    app_c2h_gen_if.master    m_axis_c2h,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      pkt_cnt_o
);
    localparam int KEEP_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic              run_q, run_prev_q;
    logic [LEN_W-1:0]  len_q, len_d, num_q, num_d;
    logic [LEN_W-1:0]  off_q, off_d, idx_q, idx_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d, tvalid_q, tvalid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              load;

    logic              run_rise, xfer;
    logic [LEN_W:0]    bt_rem;
    logic              bt_last;
    logic [KEEP_W-1:0] bt_keep;
    logic [DATA_W-1:0] bt_data;

    assign run_rise = run_q & ~run_prev_q;
    assign xfer     = tvalid_q & m_axis_c2h.tready;

    // The next beat is always built from the next-state offset/index/length,
    // so one pattern instance serves both packet start and mid-packet advance.
    assign bt_rem  = {1'b0, len_d} - {1'b0, off_d};
    assign bt_last = (bt_rem <= (LEN_W+1)'(KEEP_W));
    assign bt_keep = bt_last ? KEEP_W'(keep_mask(32'(bt_rem))) : '1;

    app_c2h_pat #(.DATA_W(DATA_W)) u_pat (
        .off_i  (off_d[7:0]),
        .idx_i  (idx_d[7:0]),
        .data_o (bt_data)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        num_d    = num_q;
        off_d    = off_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (run_rise) begin
                    len_d = pkt_len_i;
                    num_d = pkt_num_i;
                    cnt_d = '0;
                    off_d = '0;
                    idx_d = '0;
                    if (pkt_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = SEND;
                        busy_d   = 1'b1;
                        tvalid_d = 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (tlast_q) begin
                        cnt_d = cnt_q + 32'd1;
                        idx_d = idx_q + LEN_W'(1);
                        off_d = '0;
                        // Reaching the packet limit wins over a run drop.
                        if (num_q != '0 && cnt_d == 32'(num_q)) begin
                            done_d   = 1'b1;
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                        end else if (!usr_c2h0r_run_i) begin
                            state_d  = STOP;
                            tvalid_d = 1'b0;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        off_d = off_q + LEN_W'(KEEP_W);
                        load  = 1'b1;
                    end
                end
            end
            STOP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tdata_d = load ? bt_data : tdata_q;
    assign tkeep_d = load ? bt_keep : tkeep_q;
    assign tlast_d = load ? bt_last : tlast_q;

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            run_prev_q <= 1'b0;
            len_q      <= '0;
            num_q      <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= usr_c2h0r_run_i;
            run_prev_q <= run_q;
            len_q      <= len_d;
            num_q      <= num_d;
            off_q      <= off_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign m_axis_c2h.tdata  = tdata_q;
    assign m_axis_c2h.tkeep  = tkeep_q;
    assign m_axis_c2h.tlast  = tlast_q;
    assign m_axis_c2h.tvalid = tvalid_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pkt_cnt_o         = cnt_q;

endmodule

// File: tb/tb_app_c2h_gen.sv
// Bench for app_c2h_gen: directed runs plus a per-cycle stream model of the
// expected packet/byte sequence.
module tb_app_c2h_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] len = '0;
    logic [15:0] num = '0;
    logic        busy, done;
    logic [31:0] cnt;

    app_c2h_gen_if #(.DATA_W(64)) axis ();

    app_c2h_gen #(.DATA_W(64), .LEN_W(16)) dut (
        .usr_clk         (clk),
        .usr_rst_n       (rst_n),
        .usr_c2h0r_run_i (run),
        .pkt_len_i       (len),
        .pkt_num_i       (num),
        .m_axis_c2h      (axis),
        .busy_o          (busy),
        .done_o          (done),
        .pkt_cnt_o       (cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    bit mon_en = 1'b0, chk_done = 1'b1, tog_en = 1'b0;
    bit m_active = 1'b0, m_done_exp = 1'b0, stall_prev = 1'b0, xfer_prev = 1'b0;
    int m_len, m_num, m_pkt, m_beat, m_cnt;
    int xfer_cnt = 0, done_cnt = 0;
    logic [7:0]  first_b1 = '0;
    logic [7:0]  last_keep = '0;
    logic [63:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic int n_beats(input int l);
        return (l + 7) / 8;
    endfunction

    function automatic logic [63:0] exp_data(input int pkt, input int beat);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'((beat*8 + k + pkt) & 255);
        return d;
    endfunction

    function automatic logic [7:0] exp_keep(input int l, input int beat);
        int nb;
        nb = n_beats(l);
        if (beat == nb - 1) return 8'((1 << (l - (nb-1)*8)) - 1);
        return 8'hFF;
    endfunction

    // Stream model: which packet/beat must be on the bus, checked every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (axis.tvalid) begin
                chk("tvalid_vs_model", m_active, 1'b1);
                if (m_active) begin
                    chk("tdata", axis.tdata, exp_data(m_pkt, m_beat));
                    chk("tkeep", axis.tkeep, exp_keep(m_len, m_beat));
                    chk("tlast", axis.tlast, (m_beat == n_beats(m_len) - 1));
                    chk("pkt_cnt_live", cnt, m_cnt);
                end
            end
            if (stall_prev) chk("axis_hold", axis.tvalid, 1'b1);
            if (xfer_prev && m_active) chk("throughput", axis.tvalid, 1'b1);
            if (chk_done) chk("done", done, m_done_exp);
            if (done) done_cnt++;
            stall_prev = axis.tvalid & ~axis.tready;
            xfer_prev  = axis.tvalid & axis.tready;
            m_done_exp = 1'b0;
            if (m_active && axis.tvalid && axis.tready) begin
                xfer_cnt++;
                if (m_pkt == 1 && m_beat == 0) first_b1 = axis.tdata[7:0];
                if (m_beat == n_beats(m_len) - 1) begin
                    last_keep = axis.tkeep;
                    last_data = axis.tdata;
                    m_cnt++;
                    m_pkt++;
                    m_beat = 0;
                    if (m_num != 0 && m_cnt == m_num) begin
                        m_done_exp = 1'b1;
                        m_active   = 1'b0;
                    end else if (!run) begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_beat++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog_en) axis.tready = ~axis.tready;
    endtask

    task automatic start(input int l, input int n);
        len = 16'(l); num = 16'(n);
        m_len = l; m_num = n; m_pkt = 0; m_beat = 0; m_cnt = 0;
        m_active = (l != 0);
        xfer_cnt = 0; done_cnt = 0;
        run = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 2000; i++) begin
            if (!busy && !axis.tvalid) begin ok = 1'b1; break; end
            cyc();
        end
        if (!ok) chk({name, "_timeout"}, ok, 1'b1);
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) chk({name, "_timeout"}, ok, 1'b1);
    endtask

    initial begin
        bit busy_seen, tv_seen, ok;
        int dpulses;
        axis.tready = 1'b1;
        #2;
        chk("rst_tvalid", axis.tvalid, 1'b0);
        chk("rst_tdata", axis.tdata, 64'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", cnt, 32'h0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        mon_en = 1'b1;

        // Single short packet
        start(20, 1);
        wait_done("t1_done");
        chk("t1_busy_in_done", busy, 1'b1);
        chk("t1_cnt", cnt, 32'd1);
        cyc();
        chk("t1_busy_fall", busy, 1'b0);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_beats", xfer_cnt, 3);
        chk("t1_last_keep", last_keep, 8'h0F);
        chk("t1_last_data", last_data, 64'h1716151413121110);
        run = 1'b0;
        repeat (3) cyc();

        // Backpressure
        tog_en = 1'b1;
        start(64, 2);
        wait_idle("t2");
        tog_en = 1'b0;
        axis.tready = 1'b1;
        chk("t2_beats", xfer_cnt, 16);
        chk("t2_first_b1", first_b1, 8'h01);
        chk("t2_last_data", last_data, 64'h403F3E3D3C3B3A39);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_cnt", cnt, 32'd2);
        run = 1'b0;
        repeat (3) cyc();

        // Exact multiple
        start(16, 1);
        wait_idle("t3");
        chk("t3_beats", xfer_cnt, 2);
        chk("t3_last_keep", last_keep, 8'hFF);
        chk("t3_last_data", last_data, 64'h0F0E0D0C0B0A0908);
        chk("t3_done_cnt", done_cnt, 1);
        run = 1'b0;
        repeat (3) cyc();

        // Zero length
        chk_done = 1'b0;
        start(0, 5);
        busy_seen = 1'b0; tv_seen = 1'b0; dpulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (busy) busy_seen = 1'b1;
            if (axis.tvalid) tv_seen = 1'b1;
            if (done) dpulses++;
        end
        chk("t4_done_pulses", dpulses, 1);
        chk("t4_busy", busy_seen, 1'b0);
        chk("t4_tvalid", tv_seen, 1'b0);
        chk("t4_cnt", cnt, 32'd0);
        chk_done = 1'b1;
        run = 1'b0;
        repeat (3) cyc();

        // Run drop during packet index 3
        start(100, 0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (m_pkt == 3 && m_beat == 4) begin ok = 1'b1; break; end
        end
        if (!ok) chk("t5_reach_timeout", ok, 1'b1);
        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (!axis.tvalid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("t5_end_timeout", ok, 1'b1);
        chk("t5_stop_busy", busy, 1'b1);
        chk("t5_stop_cnt", cnt, 32'd4);
        cyc();
        chk("t5_idle_busy", busy, 1'b0);
        chk("t5_idle_tvalid", axis.tvalid, 1'b0);
        chk("t5_beats", xfer_cnt, 52);
        chk("t5_last_keep", last_keep, 8'h0F);
        chk("t5_last_data", last_data, 64'h6A69686766656463);
        chk("t5_no_done", done_cnt, 0);
        repeat (3) cyc();

        // Reset mid-beat with tready low
        start(64, 0);
        repeat (3) cyc();
        axis.tready = 1'b0;
        repeat (2) cyc();
        mon_en = 1'b0;
        chk("t6_pre_tvalid", axis.tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("t6_tvalid", axis.tvalid, 1'b0);
        chk("t6_tdata", axis.tdata, 64'h0);
        chk("t6_tkeep", axis.tkeep, 8'h0);
        chk("t6_tlast", axis.tlast, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_cnt", cnt, 32'h0);
        m_active = 1'b0; stall_prev = 1'b0; xfer_prev = 1'b0; m_done_exp = 1'b0;
        axis.tready = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        mon_en = 1'b1;
        start(8, 1);
        wait_done("t6_done");
        chk("t6_beats", xfer_cnt, 1);
        chk("t6_first_data", last_data, 64'h0706050403020100);
        chk("t6_cnt_after", cnt, 32'd1);
        run = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
